// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (uart_rx and uart_tx).
//   - rx_state_t   : receiver FSM state encoding
//   - DATA_BITS    : payload bits per frame (8N1)
//   - clks_per_bit : system clocks per serial bit, integer division
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } rx_state_t;

    // Truncating division: the bit period is rounded down to whole clocks.
    // The receiver relies on the result being at least 4.
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync
// N-stage flop synchroniser for a single asynchronous input. Stages reset
// to 1 so an idle-high serial line does not look like a start bit after
// reset. Reusable for any asynchronous single-bit input.
// Ports:
//   clk_i    in  1  destination clock
//   reset_ni in  1  asynchronous, active-low reset (stages go to 1)
//   d_i      in  1  asynchronous input
//   q_o      out 1  synchronised output, N cycles of latency
// Parameters:
//   N  number of flop stages, must be >= 2
// ---------------------------------------------------------------------------
module uart_sync #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] stage_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stage_q <= '1;
        end else begin
            stage_q <= {stage_q[N-2:0], d_i};
        end
    end

    assign q_o = stage_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver, 8N1, LSB first. The serial line passes through a 2-flop
// synchroniser and each bit is sampled near mid-bit. A good frame updates
// rx_byte with a one-cycle rx_dv strobe; a low stop bit discards the byte
// and raises a one-cycle frame_err strobe.
//
// Ports:
//   clk        in   1  system clock, all logic on posedge
//   reset_n    in   1  asynchronous, active-low reset
//   rx_serial  in   1  asynchronous serial line, idle high
//   rx_byte    out  8  last correctly framed byte, held until the next one
//   rx_dv      out  1  one-cycle pulse: rx_byte updated this cycle
//   frame_err  out  1  one-cycle pulse: stop bit low, byte discarded
//   rx_busy    out  1  high from start-bit detect until back in IDLE
//
// Parameters:
//   FREQUENCY  system clock frequency in Hz
//   BAUD_RATE  serial bit rate; FREQUENCY/BAUD_RATE must be >= 4
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every sample point (start check,
//   data bits, stop bit) uses the 2-of-3 majority of the synchronised line
//   at target-1, target and target+1, decided at target+1. All sampling
//   after the start check therefore moves one cycle later.
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int FREQUENCY = 10000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_dv,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(FREQUENCY, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int HALF         = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    // The start check is where the one-cycle vote delay is introduced; every
    // later sample point is a whole bit period after it, so it inherits the
    // shift without the counter ever passing CLKS_PER_BIT-1.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(HALF + 1);
`else
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(HALF);
`endif

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic rx_s;
    logic sample;

    rx_state_t             state_q,   state_d;
    logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]  shift_q,   shift_d;
    logic [DATA_BITS-1:0]  byte_q,    byte_d;
    logic                  dv_q,      dv_d;
    logic                  err_q,     err_d;
    logic                  busy_q,    busy_d;

    uart_sync #(
        .N(2)
    ) u_sync (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .d_i     (rx_serial),
        .q_o     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // vote_q[0] holds rx_s from one cycle ago, vote_q[1] from two cycles ago,
    // so together with the live rx_s they form a three-sample window.
    logic [1:0] vote_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vote_q <= 2'b11;
        end else begin
            vote_q <= {vote_q[0], rx_s};
        end
    end

    assign sample = (rx_s & vote_q[0]) | (rx_s & vote_q[1]) | (vote_q[0] & vote_q[1]);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // Strobes default low every cycle, which makes rx_dv and frame_err
    // single-cycle pulses: STOP always hands over to CLEANUP immediately.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        dv_d      = 1'b0;
        err_d     = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = START;
                    busy_d  = 1'b1;
                end
            end

            // Re-check the start bit near its middle so that short low
            // glitches on the line are rejected without any strobe.
            START: begin
                if (clk_cnt_q == START_CNT) begin
                    clk_cnt_d = '0;
                    if (!sample) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = sample;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            // The stop bit is judged at its middle; leaving for IDLE two
            // cycles later lets a back-to-back start edge be caught without
            // needing any idle time on the line.
            STOP: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    state_d   = CLEANUP;
                    if (sample) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            CLEANUP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                busy_d    = 1'b0;
            end
        endcase
    end

    assign rx_byte   = byte_q;
    assign rx_dv     = dv_q;
    assign frame_err = err_q;
    assign rx_busy   = busy_q;

endmodule
